// File: rtl/mtr_pkg.sv
// Shared constants and types for the motor PWM back end.
// MIN_DUTY is also used by the balance-control math to clamp its duty output.
package mtr_pkg;

  localparam int PWM_W        = 12;
  localparam int PERIOD       = 1 << PWM_W;
  localparam int DEADTIME_DEF = 32;

  // Smallest duty word that yields any high-side pulse with the default dead time.
  localparam int MIN_DUTY     = DEADTIME_DEF + 1;

  typedef enum logic {
    RUN   = 1'b0,
    BRAKE = 1'b1
  } drv_state_e;

endpackage

// File: rtl/mtr_pwm_drv_pwm_dt_gen.sv
// PWM counter, duty/dead-time comparators and registered complementary gate drives.
// Gate outputs lag the counter by one clock.
module pwm_dt_gen #(
  parameter int PWM_W    = 12,
  parameter int DEADTIME = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [PWM_W-1:0] duty_q,
  output logic [PWM_W-1:0] cnt,
  output logic             period_end,
  output logic             pwm_hi,
  output logic             pwm_lo
);

  localparam logic [PWM_W-1:0] DT   = PWM_W'(DEADTIME);
  localparam logic [PWM_W:0]   DT_X = (PWM_W+1)'(DEADTIME);

  logic [PWM_W:0] lo_thresh;
  logic           hi_d;
  logic           lo_d;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    // Extra bit keeps duty + DEADTIME from wrapping, so large duties suppress pwm_lo.
    lo_thresh = {1'b0, duty_q} + DT_X;
    hi_d      = run && (cnt >= DT) && (cnt < duty_q);
    lo_d      = run && ((duty_q == '0) || ({1'b0, cnt} >= lo_thresh));
  end

  assign period_end = (cnt == '1);

  // NOTE: sequential state uses non-blocking <= so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      pwm_hi <= 1'b0;
      pwm_lo <= 1'b0;
    end else begin
      cnt    <= cnt + 1'b1;
      pwm_hi <= hi_d;
      pwm_lo <= lo_d;
    end
  end

endmodule

// File: rtl/mtr_pwm_drv.sv
// One-wheel H-bridge PWM driver: period-boundary duty/direction latches and a
// RUN/BRAKE FSM that inserts one forced-off period on every direction reversal.
module mtr_pwm_drv #(
  parameter int DEADTIME = mtr_pkg::DEADTIME_DEF,
  parameter int PWM_W    = mtr_pkg::PWM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] mtr_duty,
  input  logic             rev,
  output logic             pwm_hi,
  output logic             pwm_lo,
  output logic             dir,
  output logic             brake,
  output logic             period_done
);

  import mtr_pkg::*;

  drv_state_e       state_q;
  drv_state_e       state_d;
  logic             dir_d;
  logic [PWM_W-1:0] duty_q;
  logic [PWM_W-1:0] cnt;
  logic             period_end;

  pwm_dt_gen #(
    .PWM_W    (PWM_W),
    .DEADTIME (DEADTIME)
  ) u_pwm_dt_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (state_q == RUN),
    .duty_q     (duty_q),
    .cnt        (cnt),
    .period_end (period_end),
    .pwm_hi     (pwm_hi),
    .pwm_lo     (pwm_lo)
  );

  // Direction only changes on BRAKE exit, so the bridge never reverses while driven.
  always_comb begin
    state_d = state_q;
    dir_d   = dir;
    if (period_end) begin
      unique case (state_q)
        RUN:     if (rev != dir) state_d = BRAKE;
        BRAKE: begin
          state_d = RUN;
          dir_d   = rev;
        end
        default: state_d = BRAKE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BRAKE;
      dir     <= 1'b0;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      dir     <= dir_d;
      if (period_end) duty_q <= mtr_duty;
    end
  end

  assign brake       = (state_q == BRAKE);
  assign period_done = period_end;

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Self-checking bench for mtr_pwm_drv: per-period behavioural model compared every
// cycle, plus hand-computed pulse positions/widths and dead-time gap checks.
module tb_mtr_pwm_drv;

  localparam int DT  = 32;
  localparam int PER = 4096;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic [11:0] mtr_duty = '0;
  logic        rev      = 1'b0;
  logic        pwm_hi, pwm_lo, dir, brake, period_done;

  int checks   = 0;
  int failures = 0;

  mtr_pwm_drv #(.DEADTIME(DT), .PWM_W(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mtr_duty    (mtr_duty),
    .rev         (rev),
    .pwm_hi      (pwm_hi),
    .pwm_lo      (pwm_lo),
    .dir         (dir),
    .brake       (brake),
    .period_done (period_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Period-level model: each period has one duty, one mode and one direction,
  // all decided from the inputs seen on the last clock of the previous period.
  int m_cnt   = 0;
  int m_duty  = 0;
  bit m_brake = 1'b1;
  bit m_dir   = 1'b0;
  bit m_hi    = 1'b0;
  bit m_lo    = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_duty = 0; m_brake = 1'b1; m_dir = 1'b0; m_hi = 1'b0; m_lo = 1'b0;
    end else begin
      m_hi = !m_brake && (m_cnt >= DT) && (m_cnt < m_duty);
      m_lo = !m_brake && ((m_duty == 0) || (m_cnt >= m_duty + DT));
      if (m_cnt == PER - 1) begin
        if (m_brake) begin
          m_brake = 1'b0;
          m_dir   = rev;
        end else if (rev != m_dir) begin
          m_brake = 1'b1;
        end
        m_duty = int'(mtr_duty);
      end
      m_cnt = (m_cnt + 1) % PER;
    end
  end

  // Per-window statistics, indexed by the count each gate value was computed from.
  longint cyc = 0;
  longint hi_fall, lo_fall;
  bit     hi_fall_ok, lo_fall_ok, prev_hi, prev_lo;
  int     w_hi_cnt, w_lo_cnt, w_hi_first, w_hi_last, w_lo_first;
  int     s_hi_cnt, s_lo_cnt, s_hi_first, s_hi_last, s_lo_first;

  always @(negedge clk) begin
    int src;
    cyc++;
    check("pwm_hi", pwm_hi, m_hi);
    check("pwm_lo", pwm_lo, m_lo);
    check("dir", dir, m_dir);
    check("brake", brake, m_brake);
    check("period_done", period_done, m_cnt == PER - 1);
    check("no_overlap", pwm_hi && pwm_lo, 0);
    if (!rst_n) begin
      hi_fall_ok = 1'b0; lo_fall_ok = 1'b0; prev_hi = 1'b0; prev_lo = 1'b0;
      w_hi_cnt = 0; w_lo_cnt = 0; w_hi_first = -1; w_hi_last = -1; w_lo_first = -1;
    end else begin
      if (pwm_hi && !prev_hi && lo_fall_ok) check("dt_lo_to_hi", (cyc - lo_fall) >= DT, 1);
      if (pwm_lo && !prev_lo && hi_fall_ok) check("dt_hi_to_lo", (cyc - hi_fall) >= DT, 1);
      if (!pwm_hi && prev_hi) begin hi_fall = cyc; hi_fall_ok = 1'b1; end
      if (!pwm_lo && prev_lo) begin lo_fall = cyc; lo_fall_ok = 1'b1; end
      prev_hi = pwm_hi;
      prev_lo = pwm_lo;
      src = (m_cnt + PER - 1) % PER;
      if (pwm_hi) begin
        if (w_hi_cnt == 0) w_hi_first = src;
        w_hi_last = src;
        w_hi_cnt++;
      end
      if (pwm_lo) begin
        if (w_lo_cnt == 0) w_lo_first = src;
        w_lo_cnt++;
      end
      if (src == PER - 1) begin
        s_hi_cnt = w_hi_cnt; s_lo_cnt = w_lo_cnt;
        s_hi_first = w_hi_first; s_hi_last = w_hi_last; s_lo_first = w_lo_first;
        w_hi_cnt = 0; w_lo_cnt = 0; w_hi_first = -1; w_hi_last = -1; w_lo_first = -1;
      end
    end
  end

  task automatic wait_cnt(input int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_cnt != c && n < 2 * PER);
    if (m_cnt != c) begin
      checks++;
      failures++;
      $display("FAIL wait_cnt: count %0d never reached", c);
    end
  endtask

  // Waits until the previous period's window statistics are latched.
  task automatic next_period();
    wait_cnt(1);
  endtask

  task automatic check_window(input string name, input int hi_cnt, input int lo_cnt);
    check({name, "_hi_cnt"}, s_hi_cnt, hi_cnt);
    check({name, "_lo_cnt"}, s_lo_cnt, lo_cnt);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_hi", pwm_hi, 0);
    check("rst_lo", pwm_lo, 0);
    check("rst_brake", brake, 1);
    rst_n = 1'b1;

    // Reset-release with zero duty: one brake period, then continuous low side.
    wait_cnt(4095);
    check("p0_period_done", period_done, 1);
    check("p0_brake", brake, 1);
    next_period();
    check_window("p0", 0, 0);
    check("p1_brake", brake, 0);
    mtr_duty = 12'h400;
    next_period();
    check_window("p1", 0, 4096);

    // duty 0x400
    mtr_duty = 12'd16;
    next_period();
    check_window("p2", 992, 3040);
    check("p2_hi_first", s_hi_first, 32);
    check("p2_hi_last", s_hi_last, 1023);
    check("p2_lo_first", s_lo_first, 1056);

    // duty 16: high side suppressed
    mtr_duty = 12'd4095;
    next_period();
    check_window("p3", 0, 4048);
    check("p3_lo_first", s_lo_first, 48);

    // duty 4095: low side suppressed
    mtr_duty = 12'h400;
    next_period();
    check_window("p4", 4063, 0);
    check("p4_hi_first", s_hi_first, 32);
    check("p4_hi_last", s_hi_last, 4094);

    // Mid-period duty change only takes effect at the next boundary.
    wait_cnt(500);
    mtr_duty = 12'h800;
    next_period();
    check("p5_hi_last", s_hi_last, 1023);

    // Reversal requested mid-period.
    wait_cnt(2000);
    rev = 1'b1;
    next_period();
    check("p6_hi_last", s_hi_last, 2047);
    check("p6_hi_cnt", s_hi_cnt, 2016);
    check("p6_lo_first", s_lo_first, 2080);
    check("p7_brake", brake, 1);
    check("p7_dir", dir, 0);
    next_period();
    check_window("p7", 0, 0);
    check("p8_dir", dir, 1);
    check("p8_brake", brake, 0);

    // Reverse again, then toggle back during the brake: single brake, dir stays 1.
    wait_cnt(100);
    rev = 1'b0;
    next_period();
    check("p8_hi_cnt", s_hi_cnt, 2016);
    check("p9_brake", brake, 1);
    wait_cnt(1000);
    rev = 1'b1;
    next_period();
    check_window("p9", 0, 0);
    check("p10_brake", brake, 0);
    check("p10_dir", dir, 1);

    // Asynchronous reset while the high side is on.
    wait_cnt(300);
    check("p10_hi_on", pwm_hi, 1);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    mtr_duty = '0;
    rev      = 1'b0;
    #1;
    check("async_hi", pwm_hi, 0);
    check("async_lo", pwm_lo, 0);
    check("async_brake", brake, 1);
    check("async_dir", dir, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_cnt(4095);
    check("r0_period_done", period_done, 1);
    next_period();
    check_window("r0", 0, 0);
    next_period();
    check_window("r1", 0, 4096);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
